cp0_int_responder: RTL and testbench

Coprocessor-0 block of the pipelined MIPS core. It is the CPU-side responder to the external `interrupt` line and the macroscopic-PC interface. It captures hardware interrupts, arbitrates them against synchronous exceptions reported by the M stage, and records SR, Cause and EPC. It drives the flush/redirect request to the pipeline, services `mtc0`/`mfc0`/`eret`, and latches the external interrupt until software acknowledges it.

---
 rtl/cp0_int_responder_if.sv | 33 +++
 rtl/cp0_int_responder.sv | 98 +++++++++
 tb/tb_cp0_int_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cp0_int_responder_if.sv
// Pipeline <-> CP0 bundle for cp0_int_responder.
// slave  : CP0 side. It takes the interrupt lines and the M-stage controls, and drives
//          rdata, req, handler_pc and epc_o.
// master : pipeline/testbench side, with the directions reversed.
interface cp0_int_responder_if;
  logic        interrupt;    // external device interrupt, async level
  logic [5:0]  hwint;        // timer/device lines, bit 2 replaced internally
  logic        ext_ack;      // software acknowledge pulse
  logic [31:0] pc_m;         // macroscopic PC of M instruction
  logic        bd_m;         // M instruction is in a delay slot
  logic        exc_valid_m;  // M instruction raised a sync exception
  logic [4:0]  exc_code_m;   // its ExcCode
  logic        eret_m;       // M instruction is eret
  logic        we;           // M instruction is mtc0
  logic [4:0]  cp0_addr;     // mtc0/mfc0 register number
  logic [31:0] wdata;        // mtc0 data
  logic [31:0] rdata;        // mfc0 data (combinational)
  logic        req;          // flush + redirect to handler_pc
  logic [31:0] handler_pc;   // exception entry address
  logic [31:0] epc_o;        // eret target

  modport slave (
    input  interrupt, hwint, ext_ack, pc_m, bd_m, exc_valid_m, exc_code_m,
           eret_m, we, cp0_addr, wdata,
    output rdata, req, handler_pc, epc_o
  );

  modport master (
    output interrupt, hwint, ext_ack, pc_m, bd_m, exc_valid_m, exc_code_m,
           eret_m, we, cp0_addr, wdata,
    input  rdata, req, handler_pc, epc_o
  );
endinterface

// File: rtl/cp0_int_responder.sv
// Coprocessor-0 interrupt/exception responder.
// It holds SR (12), Cause (13), EPC (14) and PRId (15). It latches the external
// interrupt until software acknowledges it. It arbitrates interrupts against
// M-stage synchronous exceptions (interrupt wins) and raises req to flush the
// pipeline.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : asynchronous, active-low
//   bus   : cp0_int_responder_if.slave (see interface for signal list)
module cp0_int_responder #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h2021_0007
) (
  input  logic                  clk,
  input  logic                  reset,
  cp0_int_responder_if.slave    bus
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic        r_ext_pend;

  logic        w_ext_pend_next;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_pc_sel;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // Set wins over acknowledge, so an interrupt that is still asserted is never dropped.
  assign w_ext_pend_next = bus.interrupt | (r_ext_pend & ~bus.ext_ack);

  assign w_int_req = r_ie & ~r_exl & (|(r_ip & r_im));
  assign w_exc_req = bus.exc_valid_m & ~r_exl;
  assign w_req     = w_int_req | w_exc_req;

  // A delay-slot instruction restarts at its branch.
  assign w_pc_sel = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exccode  <= '0;
      r_epc      <= '0;
      r_ext_pend <= 1'b0;
    end else begin
      r_ext_pend <= w_ext_pend_next;
      // The external line shows in IP on the same edge it is captured.
      r_ip       <= {bus.hwint[5:3], w_ext_pend_next, bus.hwint[1:0]};
      if (w_req) begin
        // The M instruction is cancelled, so its mtc0/eret must not land.
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? 5'd0 : bus.exc_code_m;
        r_bd      <= bus.bd_m;
        r_epc     <= {w_pc_sel[31:2], 2'b00};
      end else begin
        if (bus.eret_m) begin
          r_exl <= 1'b0;
        end else if (bus.we && bus.cp0_addr == 5'd12) begin
          r_im  <= bus.wdata[15:10];
          r_exl <= bus.wdata[1];
          r_ie  <= bus.wdata[0];
        end
        if (bus.we && bus.cp0_addr == 5'd14)
          r_epc <= {bus.wdata[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.cp0_addr)
      5'd12:   bus.rdata = w_sr;
      5'd13:   bus.rdata = w_cause;
      5'd14:   bus.rdata = r_epc;
      5'd15:   bus.rdata = PRID;
      default: bus.rdata = '0;
    endcase
  end

  assign bus.req        = w_req;
  assign bus.handler_pc = HANDLER_PC;
  assign bus.epc_o      = r_epc;

endmodule

// File: tb/tb_cp0_int_responder.sv
// Directed bench for cp0_int_responder. Inputs change 1 ns after posedge and
// outputs are sampled in the same half cycle.
module tb_cp0_int_responder;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  cp0_int_responder_if b ();

  cp0_int_responder dut (.clk(clk), .reset(reset), .bus(b.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    b.cp0_addr = a;
    #1;
    chk(tag, b.rdata, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    b.interrupt = 0; b.hwint = '0; b.ext_ack = 0; b.pc_m = '0; b.bd_m = 0;
    b.exc_valid_m = 0; b.exc_code_m = '0; b.eret_m = 0; b.we = 0;
    b.cp0_addr = '0; b.wdata = '0;
    #3;
    rd(12, 32'h0, "rst_sr");
    rd(13, 32'h0, "rst_cause");
    rd(14, 32'h0, "rst_epc");
    chk("rst_req", b.req, 1'b0);
    chk("rst_epc_o", b.epc_o, 32'h0);
    rd(15, 32'h2021_0007, "prid");
    chk("handler_pc", b.handler_pc, 32'h0000_4180);
    reset = 1'b1;
    step();

    // Interrupt taken with no delay slot
    b.we = 1; b.cp0_addr = 12; b.wdata = 32'h1401;
    step();
    b.we = 0;
    rd(12, 32'h1401, "sr_write");
    b.pc_m = 32'h3014; b.interrupt = 1;
    #1 chk("s1_req_pre", b.req, 1'b0);
    step();
    chk("s1_req_after_capture", b.req, 1'b1);
    step();
    rd(14, 32'h3014, "s1_epc");
    rd(13, 32'h1000, "s1_cause");
    rd(12, 32'h1403, "s1_sr");
    chk("s1_req_in_handler", b.req, 1'b0);
    repeat (4) step();
    b.interrupt = 0;
    b.ext_ack = 1;
    step();
    b.ext_ack = 0;
    rd(13, 32'h0, "s1_ack_cause");
    b.eret_m = 1;
    step();
    b.eret_m = 0;
    rd(12, 32'h1401, "s1_eret_sr");
    chk("s1_req_after_eret", b.req, 1'b0);

    // Interrupt taken in a delay slot
    b.bd_m = 1; b.pc_m = 32'h3018; b.interrupt = 1;
    step();
    b.interrupt = 0;
    #1 chk("s2_req", b.req, 1'b1);
    step();
    rd(14, 32'h3014, "s2_epc_bd");
    rd(13, 32'h8000_1000, "s2_cause_bd");
    b.bd_m = 0; b.ext_ack = 1;
    step();
    b.ext_ack = 0; b.eret_m = 1;
    step();
    b.eret_m = 0;

    // Interrupt stays pending while EXL=1, then fires after eret
    b.we = 1; b.cp0_addr = 12; b.wdata = 32'h1403;
    step();
    b.we = 0; b.interrupt = 1;
    step();
    chk("s3_req_masked", b.req, 1'b0);
    rd(13, 32'h8000_1000, "s3_ip_pending");
    repeat (5) step();
    b.interrupt = 0;
    chk("s3_req_still_masked", b.req, 1'b0);
    b.eret_m = 1; b.pc_m = 32'h3020; b.bd_m = 0;
    step();
    b.eret_m = 0;
    #1 chk("s3_req_after_eret", b.req, 1'b1);
    b.ext_ack = 1;
    step();
    b.ext_ack = 0;
    rd(13, 32'h0, "s3_cause_ack");
    rd(14, 32'h3020, "s3_epc");
    rd(12, 32'h1403, "s3_sr");

    // Interrupt wins over a simultaneous exception
    b.eret_m = 1;
    step();
    b.eret_m = 0; b.interrupt = 1;
    step();
    b.interrupt = 0; b.exc_valid_m = 1; b.exc_code_m = 5'd4;
    #1 chk("s4_req_both", b.req, 1'b1);
    step();
    b.exc_valid_m = 0;
    rd(13, 32'h1000, "s4_int_wins");
    b.ext_ack = 1;
    step();
    b.ext_ack = 0; b.eret_m = 1;
    step();
    b.eret_m = 0; b.exc_valid_m = 1; b.exc_code_m = 5'd4;
    #1 chk("s4_req_exc", b.req, 1'b1);
    step();
    b.exc_valid_m = 0;
    rd(13, 32'h10, "s4_exc_code4");

    // mtc0 behaviour
    b.we = 1; b.cp0_addr = 14; b.wdata = 32'h3017;
    step();
    b.we = 0;
    #1 chk("s5_epc_align", b.epc_o, 32'h3014);
    b.we = 1; b.cp0_addr = 13; b.wdata = 32'hFFFF_FFFF;
    step();
    b.we = 0;
    rd(13, 32'h10, "s5_cause_ro");
    b.eret_m = 1;
    step();
    b.eret_m = 0;
    b.exc_valid_m = 1; b.exc_code_m = 5'd5;
    b.we = 1; b.cp0_addr = 12; b.wdata = 32'h0;
    #1 chk("s5_req_with_mtc0", b.req, 1'b1);
    step();
    b.exc_valid_m = 0; b.we = 0;
    rd(12, 32'h1403, "s5_sr_mtc0_dropped");
    rd(13, 32'h14, "s5_cause_code5");
    rd(14, 32'h3020, "s5_epc_capture");

    // Sub-cycle pulses: one spans no edge, one spans an edge
    step();
    b.interrupt = 1;
    #2 b.interrupt = 0;
    step();
    rd(13, 32'h14, "s6_pulse_lost");
    @(negedge clk);
    b.interrupt = 1;
    @(posedge clk);
    #1 b.interrupt = 0;
    rd(13, 32'h1014, "s6_pulse_caught");

    // Asynchronous reset in the middle of the handler
    #1 reset = 1'b0;
    rd(12, 32'h0, "s6_rst_sr");
    rd(13, 32'h0, "s6_rst_cause");
    rd(14, 32'h0, "s6_rst_epc");
    chk("s6_rst_req", b.req, 1'b0);
    reset = 1'b1;
    step();
    rd(13, 32'h0, "s6_pend_lost");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
